// File: rtl/voice_allocator.sv
// voice_allocator: maps MIDI note events onto synth2 polyphony slots.
// Each accepted event walks the whole slot table, one slot per cycle. The walk
// collects four candidates; a decide cycle then updates the table and registers
// the synth2 outputs, which pulse for one cycle in the issue state.
module voice_allocator #(
  parameter int NUM_VOICES = 64,
  parameter int SEQ_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_type,
  input  logic [6:0] ev_note,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_velocity,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic [6:0] note,
  output logic [3:0] channel,
  output logic [6:0] velocity,
  output logic [7:0] addr,
  output logic       steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  localparam logic [1:0] EV_NOTE_ON  = 2'd0;
  localparam logic [1:0] EV_NOTE_OFF = 2'd1;
  localparam logic [1:0] EV_KEYPRESS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_ISSUE  = 2'd3
  } fsm_t;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_ACTIVE   = 2'd1,
    SLOT_RELEASED = 2'd2
  } slot_t;

  // Control
  fsm_t             state_r;
  fsm_t             state_s;
  logic             accept_s;
  logic             ev_ready_r;

  // Latched event and scan position
  logic [1:0]       ev_type_r;
  logic [6:0]       ev_note_r;
  logic [3:0]       ev_chan_r;
  logic [6:0]       ev_vel_r;
  logic [IDX_W-1:0] scan_idx_r;

  // Slot table and allocation sequence counter
  slot_t            slot_state_r [NUM_VOICES];
  logic [6:0]       slot_note_r  [NUM_VOICES];
  logic [3:0]       slot_chan_r  [NUM_VOICES];
  logic [SEQ_W-1:0] slot_stamp_r [NUM_VOICES];
  logic [SEQ_W-1:0] seq_r;

  // Slot under inspection this scan cycle
  slot_t            cur_state_s;
  logic [6:0]       cur_note_s;
  logic [3:0]       cur_chan_s;
  logic [SEQ_W-1:0] cur_age_s;
  logic             cur_match_s;

  // Scan candidates
  logic             match_found_r;
  logic [IDX_W-1:0] match_idx_r;
  slot_t            match_state_r;
  logic             free_found_r;
  logic [IDX_W-1:0] free_idx_r;
  logic             rel_found_r;
  logic [IDX_W-1:0] rel_idx_r;
  logic [SEQ_W-1:0] rel_age_r;
  logic             act_found_r;
  logic [IDX_W-1:0] act_idx_r;
  logic [SEQ_W-1:0] act_age_r;

  // Decision
  logic [1:0]       eff_type_s;
  logic             do_press_s;
  logic             do_release_s;
  logic             do_kp_s;
  logic             sel_steal_s;
  logic [IDX_W-1:0] sel_idx_s;

  // Registered outputs
  logic             pressed_r;
  logic             released_r;
  logic             keypress_r;
  logic             steal_r;
  logic [6:0]       note_r;
  logic [3:0]       chan_r;
  logic [6:0]       vel_r;
  logic [7:0]       addr_r;

  // FSM state register; ev_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ev_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      ev_ready_r <= (state_s == ST_IDLE) || (state_s == ST_ISSUE);
    end
  end

  // FSM next state and event acceptance
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_ISSUE: begin
        if (ev_valid) begin
          accept_s = 1'b1;
          state_s  = ST_SCAN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (scan_idx_r == LAST_IDX) begin
          state_s = ST_DECIDE;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DECIDE: state_s = ST_ISSUE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Read the slot at the scan index and derive its age and match status
  always_comb begin
    cur_state_s = slot_state_r[scan_idx_r];
    cur_note_s  = slot_note_r[scan_idx_r];
    cur_chan_s  = slot_chan_r[scan_idx_r];
    cur_age_s   = seq_r - slot_stamp_r[scan_idx_r];
    cur_match_s = (cur_state_s != SLOT_FREE) &&
                  (cur_note_s == ev_note_r) &&
                  (cur_chan_s == ev_chan_r);
  end

  // Latch the event on accept and walk the table collecting candidates
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_type_r     <= 2'd0;
      ev_note_r     <= 7'd0;
      ev_chan_r     <= 4'd0;
      ev_vel_r      <= 7'd0;
      scan_idx_r    <= {IDX_W{1'b0}};
      match_found_r <= 1'b0;
      match_idx_r   <= {IDX_W{1'b0}};
      match_state_r <= SLOT_FREE;
      free_found_r  <= 1'b0;
      free_idx_r    <= {IDX_W{1'b0}};
      rel_found_r   <= 1'b0;
      rel_idx_r     <= {IDX_W{1'b0}};
      rel_age_r     <= {SEQ_W{1'b0}};
      act_found_r   <= 1'b0;
      act_idx_r     <= {IDX_W{1'b0}};
      act_age_r     <= {SEQ_W{1'b0}};
    end else if (accept_s) begin
      ev_type_r     <= ev_type;
      ev_note_r     <= ev_note;
      ev_chan_r     <= ev_channel;
      ev_vel_r      <= ev_velocity;
      scan_idx_r    <= {IDX_W{1'b0}};
      match_found_r <= 1'b0;
      free_found_r  <= 1'b0;
      rel_found_r   <= 1'b0;
      rel_age_r     <= {SEQ_W{1'b0}};
      act_found_r   <= 1'b0;
      act_age_r     <= {SEQ_W{1'b0}};
    end else if (state_r == ST_SCAN) begin
      if (scan_idx_r != LAST_IDX) begin
        scan_idx_r <= scan_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (cur_match_s && !match_found_r) begin
        match_found_r <= 1'b1;
        match_idx_r   <= scan_idx_r;
        match_state_r <= cur_state_s;
      end
      if ((cur_state_s == SLOT_FREE) && !free_found_r) begin
        free_found_r <= 1'b1;
        free_idx_r   <= scan_idx_r;
      end
      // Strict compare keeps the lowest index on equal age
      if ((cur_state_s == SLOT_RELEASED) && (!rel_found_r || (cur_age_s > rel_age_r))) begin
        rel_found_r <= 1'b1;
        rel_idx_r   <= scan_idx_r;
        rel_age_r   <= cur_age_s;
      end
      if ((cur_state_s == SLOT_ACTIVE) && (!act_found_r || (cur_age_s > act_age_r))) begin
        act_found_r <= 1'b1;
        act_idx_r   <= scan_idx_r;
        act_age_r   <= cur_age_s;
      end
    end
  end

  // Choose the action and target slot from the collected candidates
  always_comb begin
    do_press_s   = 1'b0;
    do_release_s = 1'b0;
    do_kp_s      = 1'b0;
    sel_steal_s  = 1'b0;
    sel_idx_s    = {IDX_W{1'b0}};
    // note_on with zero velocity behaves exactly as note_off
    if ((ev_type_r == EV_NOTE_ON) && (ev_vel_r == 7'd0)) begin
      eff_type_s = EV_NOTE_OFF;
    end else begin
      eff_type_s = ev_type_r;
    end
    case (eff_type_s)
      EV_NOTE_ON: begin
        do_press_s = 1'b1;
        if (match_found_r) begin
          sel_idx_s = match_idx_r;
        end else if (free_found_r) begin
          sel_idx_s = free_idx_r;
        end else if (rel_found_r) begin
          sel_idx_s = rel_idx_r;
        end else begin
          sel_idx_s   = act_idx_r;
          sel_steal_s = 1'b1;
        end
      end
      EV_NOTE_OFF: begin
        if (match_found_r && (match_state_r == SLOT_ACTIVE)) begin
          do_release_s = 1'b1;
          sel_idx_s    = match_idx_r;
        end else begin
          do_release_s = 1'b0;
        end
      end
      EV_KEYPRESS: begin
        if (match_found_r && (match_state_r == SLOT_ACTIVE)) begin
          do_kp_s   = 1'b1;
          sel_idx_s = match_idx_r;
        end else begin
          do_kp_s   = 1'b0;
        end
      end
      default: begin
        do_press_s = 1'b0;
      end
    endcase
  end

  // Slot table and sequence counter update in the decide cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_r <= {SEQ_W{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        slot_state_r[i] <= SLOT_FREE;
        slot_note_r[i]  <= 7'd0;
        slot_chan_r[i]  <= 4'd0;
        slot_stamp_r[i] <= {SEQ_W{1'b0}};
      end
    end else if (state_r == ST_DECIDE) begin
      if (do_press_s) begin
        slot_state_r[sel_idx_s] <= SLOT_ACTIVE;
        slot_note_r[sel_idx_s]  <= ev_note_r;
        slot_chan_r[sel_idx_s]  <= ev_chan_r;
        slot_stamp_r[sel_idx_s] <= seq_r;
        seq_r                   <= seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
      end else if (do_release_s) begin
        slot_state_r[sel_idx_s] <= SLOT_RELEASED;
      end
    end
  end

  // Output registers: pulses live only in the issue cycle, data holds
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_r  <= 1'b0;
      released_r <= 1'b0;
      keypress_r <= 1'b0;
      steal_r    <= 1'b0;
      note_r     <= 7'd0;
      chan_r     <= 4'd0;
      vel_r      <= 7'd0;
      addr_r     <= 8'd0;
    end else if (state_r == ST_DECIDE) begin
      pressed_r  <= do_press_s;
      released_r <= do_release_s;
      keypress_r <= do_kp_s;
      steal_r    <= do_press_s & sel_steal_s;
      if (do_press_s || do_release_s || do_kp_s) begin
        note_r <= ev_note_r;
        chan_r <= ev_chan_r;
        vel_r  <= ev_vel_r;
        addr_r <= 8'(sel_idx_s);
      end
    end else begin
      pressed_r  <= 1'b0;
      released_r <= 1'b0;
      keypress_r <= 1'b0;
      steal_r    <= 1'b0;
    end
  end

  assign ev_ready      = ev_ready_r;
  assign note_pressed  = pressed_r;
  assign note_released = released_r;
  assign note_keypress = keypress_r;
  assign steal         = steal_r;
  assign note          = note_r;
  assign channel       = chan_r;
  assign velocity      = vel_r;
  assign addr          = addr_r;

endmodule
